// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory-access codes, byte-enable width and FSM states
//
// Purpose : definitions shared between the MEM stage and the data-memory responder.
// Contents: funct3 size codes, byte-enable width, responder state enum,
//           helpers for access width and byte-enable generation.
package mem_pkg;

   localparam int BE_W = 8;

   localparam logic [2:0] SZ_B   = 3'b000;
   localparam logic [2:0] SZ_H   = 3'b001;
   localparam logic [2:0] SZ_W   = 3'b010;
   localparam logic [2:0] SZ_D   = 3'b011;
   localparam logic [2:0] SZ_BU  = 3'b100;
   localparam logic [2:0] SZ_HU  = 3'b101;
   localparam logic [2:0] SZ_WU  = 3'b110;
   localparam logic [2:0] SZ_BAD = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } mem_state_t;

   // Access width in bytes; the low two bits of funct3 encode the width for
   // both signed and unsigned variants.
   function automatic logic [3:0] size_bytes(input logic [2:0] size);
      case (size[1:0])
         2'b00:   return 4'd1;
         2'b01:   return 4'd2;
         2'b10:   return 4'd4;
         default: return 4'd8;
      endcase
   endfunction

   // Contiguous byte-enable mask of the access width starting at lane.
   function automatic logic [BE_W-1:0] byte_en(input logic [2:0] size, input logic [2:0] lane);
      logic [15:0] m;
      m = (16'd1 << size_bytes(size)) - 16'd1;
      m = m << lane;
      return m[BE_W-1:0];
   endfunction

endpackage

// File: rtl/dmem_bram.sv
// rtl/dmem_bram.sv - single-port 64-bit RAM, byte write enables, 1-cycle read
//
// Purpose : backing store for dmem_responder, written so it maps onto block RAM.
// Ports   : clk   - clock
//           we    - per-byte write enables
//           addr  - word address
//           wdata - write data (byte lanes gated by we)
//           rdata - registered read data (read-before-write)
module dmem_bram
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = 10
) (
   input  logic              clk,
   input  logic [BE_W-1:0]   we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [63:0]       wdata,
   output logic [63:0]       rdata
);

   logic [63:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < BE_W; i++) begin
         if (we[i]) begin
            mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder for the MEM stage
//
// Purpose : accepts one load/store at a time, answers exactly two cycles after
//           the accepting edge with extended load data or an error flag.
// Ports   : CLK, RESET (async, active high)
//           REQ_V/REQ_READY handshake; REQ_R_W, REQ_SIZE, REQ_ADDR, REQ_DATA request
//           RSP_V one-cycle strobe; RSP_DATA, RSP_ERR held until the next response
module dmem_responder
   import mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [63:0] BASE_ADDR   = 64'h0
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        REQ_V,
   input  logic        REQ_R_W,
   input  logic [2:0]  REQ_SIZE,
   input  logic [63:0] REQ_ADDR,
   input  logic [63:0] REQ_DATA,
   output logic        REQ_READY,
   output logic        RSP_V,
   output logic [63:0] RSP_DATA,
   output logic        RSP_ERR
);

   localparam int AW = $clog2(DEPTH_WORDS);

   mem_state_t state, state_nx;

   logic        cap_r_w;
   logic [2:0]  cap_size;
   logic [63:0] cap_addr;
   logic [63:0] cap_data;

   logic        accept;
   logic [63:0] offset;
   logic [63:0] word_idx;
   logic [3:0]  nbytes;
   logic [2:0]  amask;
   logic [2:0]  lane;
   logic        misal, oor, illegal, err;

   logic [BE_W-1:0] ram_we;
   logic [AW-1:0]   ram_addr;
   logic [63:0]     ram_wdata, ram_rdata;
   logic [63:0]     sh, load_ext;

   assign REQ_READY = (state == ST_IDLE);
   assign RSP_V     = (state == ST_RESP);
   assign accept    = REQ_V && (state == ST_IDLE);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (REQ_V) state_nx = ST_ACCESS;
         ST_ACCESS: state_nx = ST_RESP;
         ST_RESP:   state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cap_r_w  <= 1'b0;
         cap_size <= SZ_B;
         cap_addr <= '0;
         cap_data <= '0;
      end else if (accept) begin
         cap_r_w  <= REQ_R_W;
         cap_size <= REQ_SIZE;
         cap_addr <= REQ_ADDR;
         cap_data <= REQ_DATA;
      end
   end

   // Request classification from the captured request.
   always_comb begin
      offset   = cap_addr - BASE_ADDR;
      word_idx = {3'b000, offset[63:3]};
      lane     = offset[2:0];
      nbytes   = size_bytes(cap_size);
      // width-1 as a 3-bit mask; for 8-byte accesses 4'd8-1 truncates to 3'b111
      amask    = 3'(nbytes - 4'd1);
      misal    = (lane & amask) != 3'b000;
      oor      = (cap_addr < BASE_ADDR) || (word_idx >= 64'(DEPTH_WORDS));
      illegal  = (cap_size == SZ_BAD) || (cap_r_w && cap_size[2]);
      err      = misal || oor || illegal;
   end

   // The RAM read is launched on the accepting edge straight from the request
   // address so the word is available during ACCESS; the write happens on the
   // ACCESS edge from the captured request. RESET gates the write so a store
   // whose ACCESS edge meets reset leaves memory untouched.
   always_comb begin
      ram_addr  = (state == ST_IDLE) ? AW'((REQ_ADDR - BASE_ADDR) >> 3) : word_idx[AW-1:0];
      ram_wdata = cap_data << {lane, 3'b000};
      ram_we    = '0;
      if ((state == ST_ACCESS) && cap_r_w && !err && !RESET) begin
         ram_we = byte_en(cap_size, lane);
      end
   end

   dmem_bram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_W      (AW)
   ) u_bram (
      .clk   (CLK),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_comb begin
      sh = ram_rdata >> {lane, 3'b000};
      case (cap_size)
         SZ_B:    load_ext = {{56{sh[7]}},  sh[7:0]};
         SZ_H:    load_ext = {{48{sh[15]}}, sh[15:0]};
         SZ_W:    load_ext = {{32{sh[31]}}, sh[31:0]};
         SZ_BU:   load_ext = {56'd0, sh[7:0]};
         SZ_HU:   load_ext = {48'd0, sh[15:0]};
         SZ_WU:   load_ext = {32'd0, sh[31:0]};
         default: load_ext = sh;
      endcase
   end

   // Response registers load only on the ACCESS edge so they stay stable
   // through RESP and until the next response.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         RSP_DATA <= '0;
         RSP_ERR  <= 1'b0;
      end else if (state == ST_ACCESS) begin
         RSP_ERR  <= err;
         RSP_DATA <= (err || cap_r_w) ? 64'd0 : load_ext;
      end
   end

endmodule
